// File: rtl/sram_bus_arbiter.sv
// ----------------------------------------------------------------------------
// sram_bus_arbiter
//
// Purpose:
//     Shares one sram-like memory port between the instruction-fetch master
//     and the data (load/store) master. One transaction is outstanding at a
//     time. When both masters ask together, the one that was not granted last
//     time wins. The granted request is latched, so the master's inputs may
//     change after the grant without disturbing the bus.
//
// Ports:
//     clk, reset                 clock, asynchronous active-high reset
//     inst_req/wr/size/addr/wdata  fetch master request
//     inst_addr_ok/data_ok/rdata   fetch master handshake and response
//     data_req/wr/size/addr/wdata  load/store master request
//     data_addr_ok/data_ok/rdata   load/store master handshake and response
//     mem_req/wr/size/addr/wdata   slave request, driven from the latch
//     mem_addr_ok/data_ok/rdata    slave handshake and response
// ----------------------------------------------------------------------------
module sram_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    // Owner and last grant both use 0 = fetch master, 1 = data master.
    logic              r_owner;
    logic              r_lastGrant;

    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_grant;
    logic              w_grantData;
    logic              w_memReq;
    logic              w_addrOk;
    logic              w_dataOk;

    // Next-state and handshake decode. Grants are only decided in IDLE, which
    // costs one cycle per transaction but keeps the arbitration decision
    // independent of the slave's combinational handshake.
    // On a tie the master that was not granted last time wins.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_grantData = 1'b0;
        w_memReq    = 1'b0;
        w_addrOk    = 1'b0;
        w_dataOk    = 1'b0;

        case (r_state)
            IDLE: begin
                if (inst_req || data_req) begin
                    w_grant     = 1'b1;
                    w_grantData = data_req && (!inst_req || !r_lastGrant);
                    w_nextState = ADDR;
                end
            end
            ADDR: begin
                w_memReq = 1'b1;
                w_addrOk = mem_addr_ok;
                // A zero-latency slave finishes the whole transaction here.
                if (mem_addr_ok && mem_data_ok) begin
                    w_dataOk    = 1'b1;
                    w_nextState = IDLE;
                end else if (mem_addr_ok) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    w_dataOk    = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Grant bookkeeping and request latch. The latch is loaded only on a
    // grant, so the slave sees the request exactly as it was in the grant
    // cycle no matter what the master does afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b0;
            r_wr        <= 1'b0;
            r_size      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else if (w_grant) begin
            r_owner     <= w_grantData;
            r_lastGrant <= w_grantData;
            if (w_grantData) begin
                r_wr    <= data_wr;
                r_size  <= data_size;
                r_addr  <= data_addr;
                r_wdata <= data_wdata;
            end else begin
                r_wr    <= inst_wr;
                r_size  <= inst_size;
                r_addr  <= inst_addr;
                r_wdata <= inst_wdata;
            end
        end
    end

    assign mem_req      = w_memReq;
    assign mem_wr       = r_wr;
    assign mem_size     = r_size;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;

    // Handshakes go only to the owner; read data is broadcast to both.
    assign inst_addr_ok = w_addrOk && !r_owner;
    assign inst_data_ok = w_dataOk && !r_owner;
    assign data_addr_ok = w_addrOk &&  r_owner;
    assign data_data_ok = w_dataOk &&  r_owner;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_bus_arbiter
//
// Directed scenarios followed by a randomized run. Inputs are driven 1 ns
// after the rising edge and outputs are observed 1 ns later, well away from
// the next edge. The randomized run tracks each master's pending request and
// the last winner, and predicts the winner, the latched bus fields and the
// owner handshakes from the arbitration rules.
// ----------------------------------------------------------------------------
module tb_sram_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;

    logic          inst_req, inst_wr;
    logic [1:0]    inst_size;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_wdata;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;

    logic          data_req, data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;

    logic          mem_req, mem_wr;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok, mem_data_ok;
    logic [DW-1:0] mem_rdata;

    logic [3:0]    oks;

    int errors = 0;
    int checks = 0;

    sram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Handshake outputs as {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}.
    assign oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic pulseReset();
        reset = 1;
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        clearInputs();
        reset = 1;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        tick(); tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (oks !== 4'b0000) begin errors++; $display("[TB] FAIL reset_oks: got %b expected 0000", oks); end
        checks++; if ({mem_wr, mem_size, mem_addr, mem_wdata} !== '0) begin errors++; $display("[TB] FAIL reset_latch: got %h/%h expected 0", mem_addr, mem_wdata); end
        clearInputs();
        reset = 0;
        tick();
        checks++; if ({mem_req, oks} !== 5'b0) begin errors++; $display("[TB] FAIL reset_idle: got %b expected 00000", {mem_req, oks}); end
    endtask

    task automatic test_single_fetch();
        $display("[TB] test_single_fetch");
        inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'hBFC00000;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL fetch_idle_req: got %b expected 0", mem_req); end
        tick();
        checks++; if ({mem_req, mem_wr, mem_size, mem_addr} !== {1'b1, 1'b0, 2'd2, 32'hBFC00000}) begin errors++; $display("[TB] FAIL fetch_bus: got req=%b addr=%h expected req=1 addr=bfc00000", mem_req, mem_addr); end
        checks++; if (oks !== 4'b0000) begin errors++; $display("[TB] FAIL fetch_wait_oks: got %b expected 0000", oks); end
        tick();
        mem_addr_ok = 1;
        #1;
        checks++; if (oks !== 4'b1000) begin errors++; $display("[TB] FAIL fetch_addr_ok: got %b expected 1000", oks); end
        tick();
        inst_req = 0; mem_addr_ok = 0;
        #1;
        checks++; if ({mem_req, oks} !== 5'b0) begin errors++; $display("[TB] FAIL fetch_data_wait: got %b expected 00000", {mem_req, oks}); end
        tick();
        mem_data_ok = 1; mem_rdata = 32'h3C1DBFC0;
        #1;
        checks++; if (oks !== 4'b0100) begin errors++; $display("[TB] FAIL fetch_data_ok: got %b expected 0100", oks); end
        checks++; if (inst_rdata !== 32'h3C1DBFC0) begin errors++; $display("[TB] FAIL fetch_rdata: got %h expected 3c1dbfc0", inst_rdata); end
        tick();
        mem_data_ok = 0;
        #1;
        checks++; if ({mem_req, oks} !== 5'b0) begin errors++; $display("[TB] FAIL fetch_back_idle: got %b expected 00000", {mem_req, oks}); end
    endtask

    task automatic test_round_robin();
        $display("[TB] test_round_robin");
        pulseReset();
        inst_req = 1; inst_size = 2; inst_addr = 32'hBFC00004;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h1FAF0000; data_wdata = 32'h12345678;
        tick();
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        checks++; if ({mem_req, mem_wr, mem_addr, mem_wdata} !== {2'b11, 32'h1FAF0000, 32'h12345678}) begin errors++; $display("[TB] FAIL tie1_data_first: got wr=%b addr=%h wdata=%h expected wr=1 addr=1faf0000 wdata=12345678", mem_wr, mem_addr, mem_wdata); end
        checks++; if (oks !== 4'b0011) begin errors++; $display("[TB] FAIL tie1_oks: got %b expected 0011", oks); end
        tick();
        data_req = 0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL tie1_idle: got %b expected 0", mem_req); end
        tick();
        #1;
        checks++; if ({mem_req, mem_wr, mem_addr} !== {2'b10, 32'hBFC00004}) begin errors++; $display("[TB] FAIL tie1_inst_next: got wr=%b addr=%h expected wr=0 addr=bfc00004", mem_wr, mem_addr); end
        checks++; if (oks !== 4'b1100) begin errors++; $display("[TB] FAIL tie1_inst_oks: got %b expected 1100", oks); end
        tick();
        data_req = 1; data_addr = 32'h1FAF0004;
        tick();
        #1;
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h1FAF0004}) begin errors++; $display("[TB] FAIL tie2_data_again: got addr=%h expected 1faf0004", mem_addr); end
        tick();
        // The still-pending fetch drops its request in IDLE and must not be granted.
        data_req = 0; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        tick();
        checks++; if ({mem_req, oks} !== 5'b0) begin errors++; $display("[TB] FAIL dropped_req: got %b expected 00000", {mem_req, oks}); end
        clearInputs();
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h00001000; data_wdata = 32'h0;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                data_addr = 32'hDEAD0000; data_size = 0;
            end
            #1;
            checks++; if ({mem_req, mem_size, mem_addr} !== {1'b1, 2'd1, 32'h00001000}) begin errors++; $display("[TB] FAIL backpressure_hold%0d: got req=%b size=%0d addr=%h expected 1/1/00001000", k, mem_req, mem_size, mem_addr); end
            checks++; if (oks !== 4'b0000) begin errors++; $display("[TB] FAIL backpressure_oks%0d: got %b expected 0000", k, oks); end
            tick();
        end
        mem_addr_ok = 1;
        #1;
        checks++; if ({oks, mem_addr} !== {4'b0010, 32'h00001000}) begin errors++; $display("[TB] FAIL backpressure_accept: got %b/%h expected 0010/00001000", oks, mem_addr); end
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hA5A5_0001;
        #1;
        checks++; if ({mem_req, oks} !== 5'b00001) begin errors++; $display("[TB] FAIL backpressure_done: got %b expected 00001", {mem_req, oks}); end
        tick();
        clearInputs();
    endtask

    task automatic test_zero_latency();
        $display("[TB] test_zero_latency");
        inst_req = 1; inst_size = 2; inst_addr = 32'hBFC00100;
        tick();
        mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'h0BAD_CAFE;
        #1;
        checks++; if (oks !== 4'b1100) begin errors++; $display("[TB] FAIL zero_lat_oks: got %b expected 1100", oks); end
        checks++; if ({inst_rdata, data_rdata} !== {2{32'h0BAD_CAFE}}) begin errors++; $display("[TB] FAIL zero_lat_rdata: got %h/%h expected 0badcafe", inst_rdata, data_rdata); end
        tick();
        // Slave handshakes are still high, but the arbiter is back in IDLE.
        inst_req = 0;
        #1;
        checks++; if ({mem_req, oks} !== 5'b0) begin errors++; $display("[TB] FAIL zero_lat_idle: got %b expected 00000", {mem_req, oks}); end
        tick();
        clearInputs();
    endtask

    task automatic test_reset_in_data();
        $display("[TB] test_reset_in_data");
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h00002000; data_wdata = 32'hCAFEF00D;
        tick();
        mem_addr_ok = 1;
        #1;
        checks++; if (oks !== 4'b0010) begin errors++; $display("[TB] FAIL rst_data_accept: got %b expected 0010", oks); end
        tick();
        data_req = 0; mem_addr_ok = 0;
        #1;
        reset = 1; mem_data_ok = 1;
        #1;
        checks++; if ({mem_req, oks} !== 5'b0) begin errors++; $display("[TB] FAIL rst_async_clear: got %b expected 00000", {mem_req, oks}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_latch_clear: got %h expected 00000000", mem_addr); end
        tick();
        reset = 0; mem_data_ok = 0;
        inst_req = 1; inst_size = 2; inst_addr = 32'h00003000;
        data_req = 1; data_wr = 0; data_addr = 32'h00004000;
        #1;
        checks++; if ({mem_req, oks} !== 5'b0) begin errors++; $display("[TB] FAIL rst_release_idle: got %b expected 00000", {mem_req, oks}); end
        tick();
        mem_addr_ok = 1; mem_data_ok = 1;
        #1;
        checks++; if ({mem_req, mem_addr, oks} !== {1'b1, 32'h00004000, 4'b0011}) begin errors++; $display("[TB] FAIL rst_tie_to_data: got addr=%h oks=%b expected 00004000/0011", mem_addr, oks); end
        tick();
        clearInputs();
        tick();
    endtask

    task automatic test_random();
        bit          pendI, pendD, winD, lastD, aok, dok;
        logic        eWr;
        logic [1:0]  eSize;
        logic [31:0] eAddr, eWdata;
        logic [3:0]  eOks;
        int          aLat, dLat;
        $display("[TB] test_random");
        clearInputs();
        pulseReset();
        lastD = 0; pendI = 0; pendD = 0;
        for (int r = 0; r < 60; r++) begin
            if (!pendI && ($urandom % 2 == 1)) begin
                pendI = 1;
                inst_wr = 1'($urandom); inst_size = 2'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!pendD && ($urandom % 2 == 1)) begin
                pendD = 1;
                data_wr = 1'($urandom); data_size = 2'($urandom); data_addr = $urandom; data_wdata = $urandom;
            end
            if (!pendI && !pendD) begin
                pendD = 1;
                data_wr = 1'($urandom); data_size = 2'($urandom); data_addr = $urandom; data_wdata = $urandom;
            end
            inst_req = pendI; data_req = pendD;
            winD = (pendI && pendD) ? !lastD : pendD;
            lastD = winD;
            eWr    = winD ? data_wr    : inst_wr;
            eSize  = winD ? data_size  : inst_size;
            eAddr  = winD ? data_addr  : inst_addr;
            eWdata = winD ? data_wdata : inst_wdata;
            aLat = $urandom_range(0, 3);
            dLat = $urandom_range(0, 3);
            // A stray slave data_ok while idle must not reach either master.
            mem_addr_ok = 0; mem_data_ok = 1'($urandom);
            #1;
            checks++; if ({mem_req, oks} !== 5'b0) begin errors++; $display("[TB] FAIL rnd_idle r%0d: got %b expected 00000", r, {mem_req, oks}); end
            tick();
            for (int k = 0; k <= aLat; k++) begin
                if (k >= 1) begin
                    if (winD) begin data_addr = $urandom; data_wdata = $urandom; data_wr = 1'($urandom); end
                    else begin inst_addr = $urandom; inst_wdata = $urandom; inst_size = 2'($urandom); end
                end
                aok = (k == aLat);
                dok = aok && (dLat == 0);
                mem_addr_ok = aok; mem_data_ok = dok; mem_rdata = $urandom;
                eOks = winD ? {2'b00, aok, dok} : {aok, dok, 2'b00};
                #1;
                checks++; if ({mem_req, mem_wr, mem_size, mem_addr, mem_wdata} !== {1'b1, eWr, eSize, eAddr, eWdata}) begin errors++; $display("[TB] FAIL rnd_bus r%0d k%0d: got req=%b wr=%b size=%0d addr=%h wdata=%h expected 1/%b/%0d/%h/%h", r, k, mem_req, mem_wr, mem_size, mem_addr, mem_wdata, eWr, eSize, eAddr, eWdata); end
                checks++; if (oks !== eOks) begin errors++; $display("[TB] FAIL rnd_addr_oks r%0d k%0d: got %b expected %b", r, k, oks, eOks); end
                checks++; if ({inst_rdata, data_rdata} !== {mem_rdata, mem_rdata}) begin errors++; $display("[TB] FAIL rnd_rdata r%0d: got %h/%h expected %h", r, inst_rdata, data_rdata, mem_rdata); end
                tick();
            end
            if (winD) begin pendD = 0; data_req = 0; end
            else begin pendI = 0; inst_req = 0; end
            mem_addr_ok = 0;
            for (int j = 1; j <= dLat; j++) begin
                dok = (j == dLat);
                mem_data_ok = dok; mem_rdata = $urandom;
                eOks = winD ? {3'b000, dok} : {1'b0, dok, 2'b00};
                #1;
                checks++; if ({mem_req, oks} !== {1'b0, eOks}) begin errors++; $display("[TB] FAIL rnd_data_oks r%0d j%0d: got %b expected %b", r, j, {mem_req, oks}, {1'b0, eOks}); end
                tick();
            end
        end
        clearInputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        reset = 1;
        #2;
        test_reset();
        test_single_fetch();
        test_round_robin();
        test_backpressure();
        test_zero_latency();
        test_reset_in_data();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
